// File: rtl/ibex_data_axi4l_bridge_if.sv
// Shared AXI4-Lite types and the AXI4-Lite channel bundle used by the Ibex data-port bridge.
// The master modport also drives the bundle's aclk/aresetn.
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi4l_if;
  import axi4l_pkg::*;

  logic  aclk;
  logic  aresetn;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;

  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;

  resp_t bresp;
  logic  bvalid;
  logic  bready;

  addr_t araddr;
  logic  arvalid;
  logic  arready;

  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output aclk, aresetn,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/ibex_data_axi4l_bridge.sv
// Converts the Ibex LSU req/gnt/rvalid data port into single-outstanding AXI4-Lite transfers.
// Transfer direction is carried by the FSM state, so no separate we flop is kept.
module ibex_data_axi4l_bridge
  import axi4l_pkg::*;
(
  input  logic    aclk,
  input  logic    aresetn,
  input  logic    data_req,
  output logic    data_gnt,
  input  logic    data_we,
  input  strb_t   data_be,
  input  addr_t   data_addr,
  input  data_t   data_wdata,
  output logic    data_rvalid,
  output data_t   data_rdata,
  output logic    data_err,
  axi4l_if.master axi
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic   awvalid_q, awvalid_d;
  logic   wvalid_q, wvalid_d;
  logic   arvalid_q, arvalid_d;
  logic   err_q, err_d;
  data_t  rdata_q, rdata_d;
  addr_t  addr_q, addr_d;
  data_t  wdata_q, wdata_d;
  strb_t  be_q, be_d;

  assign axi.aclk    = aclk;
  assign axi.aresetn = aresetn;

  assign data_gnt = data_req && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;

    unique case (state_q)
      IDLE: begin
        if (data_gnt) begin
          addr_d    = data_addr;
          wdata_d   = data_wdata;
          be_d      = data_be;
          awvalid_d = data_we;
          wvalid_d  = data_we;
          arvalid_d = !data_we;
          state_d   = data_we ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W retire independently; leave once neither is still pending.
        if (axi.awready) awvalid_d = 1'b0;
        if (axi.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          err_d   = (axi.bresp != RESP_OKAY);
          state_d = RESP;
        end
      end
      RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.rvalid) begin
          rdata_d = axi.rdata;
          err_d   = (axi.rresp != RESP_OKAY);
          state_d = RESP;
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Request payload is only meaningful after a grant, so it carries no reset.
  always_ff @(posedge aclk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = (state_q == WR_RESP);
  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = (state_q == RD_DATA);

  assign data_rvalid = (state_q == RESP);
  assign data_rdata  = rdata_q;
  assign data_err    = err_q;

endmodule

// File: tb/tb_ibex_data_axi4l_bridge.sv
// Bench for ibex_data_axi4l_bridge: directed scenarios plus randomized traffic against a
// word-array memory model and an AXI4-Lite slave with random stalls and an SLVERR region.
module tb_ibex_data_axi4l_bridge;
  import axi4l_pkg::*;

  logic  aclk    = 1'b0;
  logic  aresetn = 1'b1;
  logic  data_req = 1'b0;
  logic  data_we  = 1'b0;
  strb_t data_be    = '0;
  addr_t data_addr  = '0;
  data_t data_wdata = '0;
  logic  data_gnt, data_rvalid, data_err;
  data_t data_rdata;

  axi4l_if axi();

  ibex_data_axi4l_bridge dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .data_req   (data_req),
    .data_gnt   (data_gnt),
    .data_we    (data_we),
    .data_be    (data_be),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .data_err   (data_err),
    .axi        (axi)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scenario controls and the transaction currently owned by the bridge
  bit    rand_mode = 1'b0;
  int    aw_stall  = 0;
  bit    r_block   = 1'b0;
  bit    cur_we    = 1'b0;
  addr_t cur_addr  = '0;
  data_t cur_wdata = '0;
  strb_t cur_be    = '0;

  // Reference memory: 16 words, word index addr[5:2]; addr[5:4]==3 answers SLVERR
  data_t ref_mem [16];
  data_t last_rd = '0;
  int    txn_awhi, txn_whi;

  // ---------------- AXI4-Lite slave ----------------
  data_t smem [16];
  bit    aw_got, w_got, ar_got, b_hs, r_hs;
  bit    aw_hs_now, w_hs_now, ar_hs_now;
  bit    prev_awv, prev_aw_hs, prev_wv, prev_w_hs, prev_arv, prev_ar_hs;
  addr_t prev_awaddr, prev_araddr, aw_a, ar_a, last_awaddr, last_araddr;
  data_t prev_wdata, w_d;
  strb_t w_s, last_wstrb;
  int    b_wait, r_wait, aw_seen;
  int    aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hi, w_hi;

  initial begin
    for (int i = 0; i < 16; i++) smem[i] = 32'hA5A5_0000 | i;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = RESP_OKAY;
    axi.rvalid = 1'b0; axi.rresp = RESP_OKAY; axi.rdata = '0;
    b_wait = -1; r_wait = -1; aw_seen = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; aw_hi = 0; w_hi = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.rvalid = 1'b0;
        aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
        prev_awv = 0; prev_aw_hs = 0; prev_wv = 0; prev_w_hs = 0; prev_arv = 0; prev_ar_hs = 0;
        b_wait = -1; r_wait = -1; aw_seen = 0;
        continue;
      end
      if (b_hs) begin axi.bvalid = 1'b0; b_hs = 0; end
      if (r_hs) begin axi.rvalid = 1'b0; r_hs = 0; end

      if (aw_got && w_got && !axi.bvalid) begin
        if (b_wait < 0) b_wait = rand_mode ? int'($urandom_range(0, 2)) : 0;
        if (b_wait == 0) begin
          if (aw_a[5:4] != 2'b11)
            for (int b = 0; b < 4; b++)
              if (w_s[b]) smem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
          axi.bresp  = (aw_a[5:4] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
          axi.bvalid = 1'b1;
          aw_got = 0; w_got = 0; b_wait = -1;
        end else b_wait--;
      end
      if (ar_got && !axi.rvalid && !r_block) begin
        if (r_wait < 0) r_wait = rand_mode ? int'($urandom_range(0, 2)) : 0;
        if (r_wait == 0) begin
          axi.rresp  = (ar_a[5:4] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
          axi.rdata  = (ar_a[5:4] == 2'b11) ? 32'h1234_5678 : smem[ar_a[5:2]];
          axi.rvalid = 1'b1;
          ar_got = 0; r_wait = -1;
        end else r_wait--;
      end

      // Direction exclusivity and hold-until-handshake stability
      if (axi.awvalid) begin aw_hi++; chk("aw_in_read", 32'(cur_we), 32'd1); end
      if (axi.wvalid)  begin w_hi++;  chk("w_in_read", 32'(cur_we), 32'd1); end
      if (axi.arvalid) chk("ar_in_write", 32'(cur_we), 32'd0);
      if (prev_awv && !prev_aw_hs) begin
        chk("aw_hold", 32'(axi.awvalid), 32'd1);
        chk("aw_stable", axi.awaddr, prev_awaddr);
      end
      if (prev_wv && !prev_w_hs) begin
        chk("w_hold", 32'(axi.wvalid), 32'd1);
        chk("w_stable", axi.wdata, prev_wdata);
      end
      if (prev_arv && !prev_ar_hs) begin
        chk("ar_hold", 32'(axi.arvalid), 32'd1);
        chk("ar_stable", axi.araddr, prev_araddr);
      end

      axi.awready = rand_mode ? 1'($urandom_range(0, 1)) : (aw_seen >= aw_stall);
      axi.wready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

      aw_hs_now = axi.awvalid && axi.awready;
      w_hs_now  = axi.wvalid && axi.wready;
      ar_hs_now = axi.arvalid && axi.arready;
      if (aw_hs_now) begin
        aw_got = 1; aw_a = axi.awaddr; last_awaddr = axi.awaddr; aw_cnt++; aw_seen = 0;
        chk("awaddr", axi.awaddr, cur_addr);
      end else if (axi.awvalid) aw_seen++;
      if (w_hs_now) begin
        w_got = 1; w_d = axi.wdata; w_s = axi.wstrb; last_wstrb = axi.wstrb; w_cnt++;
        chk("wdata", axi.wdata, cur_wdata);
        chk("wstrb", 32'(axi.wstrb), 32'(cur_be));
      end
      if (ar_hs_now) begin
        ar_got = 1; ar_a = axi.araddr; last_araddr = axi.araddr; ar_cnt++;
        chk("araddr", axi.araddr, cur_addr);
      end
      b_hs = axi.bvalid && axi.bready;
      r_hs = axi.rvalid && axi.rready;
      if (b_hs) b_cnt++;
      if (r_hs) r_cnt++;

      prev_awv = axi.awvalid; prev_aw_hs = aw_hs_now; prev_awaddr = axi.awaddr;
      prev_wv  = axi.wvalid;  prev_w_hs  = w_hs_now;  prev_wdata  = axi.wdata;
      prev_arv = axi.arvalid; prev_ar_hs = ar_hs_now; prev_araddr = axi.araddr;
    end
  end

  // ---------------- core-side driver and reference model ----------------
  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic do_txn(input bit we, input addr_t addr, input data_t wd, input strb_t be,
                        input bit keep, input bit chk_lat);
    bit    got;
    bit    exp_e;
    data_t exp_rd;
    int    lat;
    int    aw0, w0, b0, ar0, r0, awh0, wh0;
    data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd; data_be = be;
    #1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (data_gnt) begin got = 1; break; end
      step();
    end
    if (!got) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      data_req = 1'b0;
      return;
    end
    cur_we = we; cur_addr = addr; cur_wdata = wd; cur_be = be;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt; awh0 = aw_hi; wh0 = w_hi;
    exp_e  = (addr[5:4] == 2'b11);
    exp_rd = exp_e ? 32'h1234_5678 : ref_mem[addr[5:2]];
    if (we && !exp_e)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];

    step();
    if (!keep) data_req = 1'b0;
    got = 0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (data_rvalid) begin got = 1; lat = k; break; end
      chk("err_no_rvalid", 32'(data_err), 32'd0);
      chk("rdata_hold", data_rdata, last_rd);
      if (data_req) chk("gnt_busy", 32'(data_gnt), 32'd0);
      step();
    end
    if (!got) begin
      chk("rvalid_timeout", 32'd0, 32'd1);
      return;
    end
    if (chk_lat) chk("latency", 32'(lat), 32'd3);
    if (data_req) chk("gnt_in_resp", 32'(data_gnt), 32'd0);
    chk("err", 32'(data_err), 32'(exp_e));
    if (!we) begin
      chk("rdata", data_rdata, exp_rd);
      last_rd = exp_rd;
    end
    chk("aw_count", 32'(aw_cnt - aw0), we ? 32'd1 : 32'd0);
    chk("w_count", 32'(w_cnt - w0), we ? 32'd1 : 32'd0);
    chk("b_count", 32'(b_cnt - b0), we ? 32'd1 : 32'd0);
    chk("ar_count", 32'(ar_cnt - ar0), we ? 32'd0 : 32'd1);
    chk("r_count", 32'(r_cnt - r0), we ? 32'd0 : 32'd1);
    txn_awhi = aw_hi - awh0;
    txn_whi  = w_hi - wh0;
    step();
    chk("rvalid_pulse", 32'(data_rvalid), 32'd0);
    chk("err_after", 32'(data_err), 32'd0);
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 | i;
    #1 aresetn = 1'b0;
    step();
    step();
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_bready", 32'(axi.bready), 32'd0);
    chk("rst_rready", 32'(axi.rready), 32'd0);
    chk("rst_rvalid", 32'(data_rvalid), 32'd0);
    chk("rst_err", 32'(data_err), 32'd0);
    chk("rst_rdata", data_rdata, 32'd0);
    aresetn = 1'b1;
    step();

    // Zero-wait write then read-back of the same word
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
    chk("w36_awaddr", last_awaddr, 32'h0000_0010);
    chk("w36_wstrb", 32'(last_wstrb), 32'hF);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1);
    chk("r37_araddr", last_araddr, 32'h0000_0010);
    chk("r37_rdata", data_rdata, 32'hDEAD_BEEF);

    // AW accepted only after three stalled cycles, W accepted at once
    aw_stall = 3;
    do_txn(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'h5, 1'b0, 1'b0);
    aw_stall = 0;
    chk("w38_awvalid_cycles", 32'(txn_awhi), 32'd4);
    chk("w38_wvalid_cycles", 32'(txn_whi), 32'd1);

    // Read from the SLVERR region
    do_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0, 1'b1);
    step();
    chk("r39_rdata_hold", data_rdata, 32'h1234_5678);

    // Back-to-back alternating traffic with data_req never dropped
    for (int i = 0; i < 6; i++)
      do_txn(i[0] == 1'b0, 32'h0000_0000 | (32'(i) << 2), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1, 1'b1);
    data_req = 1'b0;
    step();

    // Reset while the bridge waits in RD_DATA
    r_block = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0014;
    #1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (data_gnt) begin got = 1; break; end
      step();
    end
    cur_we = 1'b0; cur_addr = 32'h0000_0014;
    step();
    data_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (axi.rready) break;
      step();
    end
    chk("rst41_reached_rd_data", 32'(got && axi.rready), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("rst41_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst41_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst41_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst41_bready", 32'(axi.bready), 32'd0);
    chk("rst41_rready", 32'(axi.rready), 32'd0);
    chk("rst41_rvalid", 32'(data_rvalid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst41_no_rvalid", 32'(data_rvalid), 32'd0);
    end
    r_block = 1'b0;
    last_rd = '0;
    aresetn = 1'b1;
    step();
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1);

    // Randomized traffic with random slave stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      bit    we;
      bit    keep;
      addr_t a;
      we   = 1'($urandom_range(0, 1));
      keep = 1'($urandom_range(0, 1));
      a    = $urandom & 32'h0000_0F3C;
      do_txn(we, a, $urandom, 4'($urandom_range(1, 15)), keep, 1'b0);
      if (!keep) repeat ($urandom_range(0, 2)) step();
    end
    data_req = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/ibex_data_axi4l_bridge.md
IBEX_DATA_AXI4L_BRIDGE -- requirements
Module: ibex_data_axi4l_bridge

Interface
REQ-001 SHALL have no parameters; address/data widths follow axi4l_pkg (addr_t, data_t, strb_t = 32/32/4 bits).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named aclk and aresetn as in the rest of the codebase.
REQ-003 aclk  input  1  clock; all state updates on its rising edge.
REQ-004 aresetn  input  1  asynchronous active-low reset.
REQ-005 data_req  input  1  core requests a transfer.
REQ-006 data_gnt  output  1  request accepted this cycle; address/control/wdata are sampled.
REQ-007 data_we  input  1  1 = write, 0 = read.
REQ-008 data_be  input  4  byte enables.
REQ-009 data_addr  input  32  byte address.
REQ-010 data_wdata  input  32  write data.
REQ-011 data_rvalid  output  1  one-cycle response pulse for each granted request.
REQ-012 data_rdata  output  32  read data, valid with data_rvalid on reads.
REQ-013 data_err  output  1  response error, valid with data_rvalid.
REQ-014 axi  axi4l_if.master  -  AXI4-Lite master port (aw/w/b/ar/r channels); axi.aclk/axi.aresetn driven from aclk/aresetn.

Function
REQ-015 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
REQ-016 data_gnt SHALL equal data_req && (state == IDLE), combinationally; at most one transfer outstanding.
REQ-017 On grant SHALL register addr, be, wdata, we; next state WR_ADDR_DATA if we else RD_ADDR.
REQ-018 On a write grant SHALL set awvalid and wvalid together in the following cycle.
REQ-019 awaddr SHALL be the registered addr unmodified; wdata/wstrb the registered wdata/be.
REQ-020 awvalid and wvalid SHALL each stay high, with stable payload, until their own handshake, then drop independently; either order or simultaneous acceptance is legal.
REQ-021 SHALL enter WR_RESP once both AW and W handshakes are complete, including when both complete in the same cycle.
REQ-022 In WR_RESP bready SHALL be 1; bready SHALL be 0 in all other states.
REQ-023 On B handshake SHALL go to RESP with data_err = (bresp != OKAY).
REQ-024 On a read grant SHALL set arvalid the following cycle with araddr = registered addr, held until arready, then go to RD_DATA.
REQ-025 In RD_DATA rready SHALL be 1 (0 elsewhere); on R handshake SHALL register rdata into data_rdata and data_err = (rresp != OKAY), then go to RESP.
REQ-026 In RESP data_rvalid SHALL be 1 for exactly one cycle, then IDLE; data_gnt SHALL be 0 in RESP.
REQ-027 Minimum latency grant -> data_rvalid SHALL be 3 cycles with a zero-wait slave (grant, handshake, B/R handshake, RESP).
REQ-028 data_rdata SHALL hold its last value outside RESP; on writes it is don't-care for the core.
REQ-029 data_err SHALL be 0 whenever data_rvalid is 0.
REQ-030 Requests that arrive while not in IDLE SHALL receive no grant and SHALL NOT be lost if the core holds data_req.
REQ-031 SHALL never assert awvalid/wvalid/arvalid in the same cycle as a read/write of the other direction.
REQ-032 SHALL tolerate a slave that asserts bvalid/rvalid with no wait states.

Reset
REQ-033 aresetn low SHALL force state IDLE immediately, regardless of clock.
REQ-034 Reset values: awvalid, wvalid, arvalid, bready, rready, data_rvalid, data_err = 0; data_rdata = 0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no data_rvalid; the first request after reset release SHALL be granted in IDLE.

Verification
REQ-036 Write addr 0x0000_0010, wdata 0xDEAD_BEEF, be 4'hF, zero-wait slave -> one AW+W handshake with awaddr 0x10, wstrb 4'hF; data_rvalid=1, data_err=0 exactly 3 cycles after grant.
REQ-037 Read addr 0x0000_0010 after REQ-036 with memory slave -> araddr 0x10; data_rvalid with data_rdata 0xDEAD_BEEF, data_err=0.
REQ-038 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable 0x10; exactly one B accepted; one data_rvalid.
REQ-039 Read answered with rresp=SLVERR, rdata 0x1234_5678 -> data_rvalid=1, data_err=1, data_rdata 0x1234_5678; next cycle data_err=0.
REQ-040 data_req held high continuously for alternating write/read -> data_gnt only in IDLE, one grant per data_rvalid, no overlapping AXI channels.
REQ-041 aresetn pulsed low while in RD_DATA -> all valids/readies 0 asynchronously, no data_rvalid; after release a new read is granted and completes normally.
